// File: rtl/gpio_pad_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_ctrl_pkg
// Description : Shared types and default sizes for the GPIO pad controller.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pad_ctrl_pkg;

    localparam int c_DEF_GPIO_NUM = 8;
    localparam int c_DEF_DB_WIDTH = 8;

    typedef enum logic [1:0] {
        IRQ_RISE  = 2'b00,
        IRQ_FALL  = 2'b01,
        IRQ_BOTH  = 2'b10,
        IRQ_LEVEL = 2'b11
    } irq_type_e;

endpackage
`default_nettype wire

// File: rtl/gpio_pad_filter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_filter
// Description : Single-pin receive path: 2-flop sync, debounce, event decode.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pad_filter
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int DB_WIDTH = c_DEF_DB_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_pad,
    input  logic [DB_WIDTH-1:0] i_thr,
    input  logic [1:0]          i_type,
    output logic                o_filt,
    output logic                o_event
);

    localparam logic [DB_WIDTH-1:0] c_ONE = {{(DB_WIDTH-1){1'b0}}, 1'b1};

    logic                r_sync1;
    logic                r_sync2;
    logic                r_filt;
    logic                r_filt_q;
    logic [DB_WIDTH-1:0] r_cnt;
    logic [DB_WIDTH-1:0] w_lim;
    irq_type_e           w_type;

    // A threshold of 0 behaves like 1: the filtered value follows one edge later.
    always_comb begin
        w_lim = (i_thr == '0) ? '0 : (i_thr - c_ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_filt   <= 1'b0;
            r_filt_q <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= i_pad;
            r_sync2  <= r_sync1;
            r_filt_q <= r_filt;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt >= w_lim) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    always_comb begin
        w_type  = irq_type_e'(i_type);
        o_event = 1'b0;
        case (w_type)
            IRQ_RISE:  o_event = r_filt & ~r_filt_q;
            IRQ_FALL:  o_event = ~r_filt & r_filt_q;
            IRQ_BOTH:  o_event = r_filt ^ r_filt_q;
            IRQ_LEVEL: o_event = r_filt;
            default:   o_event = 1'b0;
        endcase
    end

    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pad_ctrl
// Description : Pad-ring driver/receiver with debounce and sticky interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pad_ctrl
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int GPIO_NUM = c_DEF_GPIO_NUM,
    parameter int DB_WIDTH = c_DEF_DB_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [GPIO_NUM-1:0]   dir_i,
    input  logic [GPIO_NUM-1:0]   out_i,
    input  logic [GPIO_NUM-1:0]   pu_en_i,
    input  logic [DB_WIDTH-1:0]   db_thr_i,
    input  logic [GPIO_NUM-1:0]   irq_en_i,
    input  logic [2*GPIO_NUM-1:0] irq_type_i,
    input  logic [GPIO_NUM-1:0]   irq_clr_i,
    input  logic [GPIO_NUM-1:0]   pad_c_i,
    output logic [GPIO_NUM-1:0]   pad_i_o,
    output logic [GPIO_NUM-1:0]   pad_oen_o,
    output logic [GPIO_NUM-1:0]   pad_ren_o,
    output logic [GPIO_NUM-1:0]   in_o,
    output logic [GPIO_NUM-1:0]   irq_pend_o,
    output logic                  irq_o
);

    logic [GPIO_NUM-1:0] r_pad_i;
    logic [GPIO_NUM-1:0] r_pad_oen;
    logic [GPIO_NUM-1:0] r_pad_ren;
    logic [GPIO_NUM-1:0] r_pend;
    logic [GPIO_NUM-1:0] w_filt;
    logic [GPIO_NUM-1:0] w_event;

    generate
        for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
            gpio_pad_filter #(
                .DB_WIDTH (DB_WIDTH)
            ) u_filter (
                .clk     (clk_i),
                .rst     (rst_i),
                .i_pad   (pad_c_i[g]),
                .i_thr   (db_thr_i),
                .i_type  (irq_type_i[2*g +: 2]),
                .o_filt  (w_filt[g]),
                .o_event (w_event[g])
            );
        end
    endgenerate

    // Pulls default on so undriven pads do not float out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pad_i   <= '0;
            r_pad_oen <= '1;
            r_pad_ren <= '0;
            r_pend    <= '0;
        end else begin
            r_pad_i   <= out_i;
            r_pad_oen <= ~dir_i;
            r_pad_ren <= ~pu_en_i;
            r_pend    <= (r_pend & ~irq_clr_i) | (irq_en_i & w_event);
        end
    end

    assign pad_i_o    = r_pad_i;
    assign pad_oen_o  = r_pad_oen;
    assign pad_ren_o  = r_pad_ren;
    assign in_o       = w_filt;
    assign irq_pend_o = r_pend;
    assign irq_o      = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_pad_ctrl
// Description : Scoreboard bench for gpio_pad_ctrl (8 pins, 8-bit threshold).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_pad_ctrl;

    localparam int c_SEL_PAD_I = 0;
    localparam int c_SEL_OEN   = 1;
    localparam int c_SEL_REN   = 2;
    localparam int c_SEL_IN    = 3;
    localparam int c_SEL_PEND  = 4;
    localparam int c_SEL_IRQ   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dir, out, pu_en, db_thr, irq_en, irq_clr, pad_c;
    logic [15:0] irq_type;
    logic [7:0]  pad_i, pad_oen, pad_ren, in_v, pend;
    logic        irq;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(
        .GPIO_NUM (8),
        .DB_WIDTH (8)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .dir_i      (dir),
        .out_i      (out),
        .pu_en_i    (pu_en),
        .db_thr_i   (db_thr),
        .irq_en_i   (irq_en),
        .irq_type_i (irq_type),
        .irq_clr_i  (irq_clr),
        .pad_c_i    (pad_c),
        .pad_i_o    (pad_i),
        .pad_oen_o  (pad_oen),
        .pad_ren_o  (pad_ren),
        .in_o       (in_v),
        .irq_pend_o (pend),
        .irq_o      (irq)
    );

    typedef struct {
        int         due;
        int         sel;
        logic [7:0] mask;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            c_SEL_PAD_I: return pad_i;
            c_SEL_OEN:   return pad_oen;
            c_SEL_REN:   return pad_ren;
            c_SEL_IN:    return in_v;
            c_SEL_PEND:  return pend;
            default:     return {7'b0, irq};
        endcase
    endfunction

    task automatic expect_at(input int sel, input int dly, input logic [7:0] mask,
                             input logic [7:0] val, input string tag);
        exp_t e;
        e.due  = cyc + dly;
        e.sel  = sel;
        e.mask = mask;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, int'(observe(sb[i].sel) & sb[i].mask),
                      int'(sb[i].val & sb[i].mask));
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        dir      = 8'($urandom);
        out      = 8'($urandom);
        pu_en    = 8'($urandom);
        db_thr   = 8'($urandom);
        irq_en   = 8'($urandom);
        irq_type = 16'($urandom);
        irq_clr  = 8'($urandom);
        pad_c    = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        randomize_inputs();
        repeat (3) begin
            step(1);
            expect_at(c_SEL_OEN,   0, 8'hFF, 8'hFF, "rst_oen");
            expect_at(c_SEL_REN,   0, 8'hFF, 8'h00, "rst_ren");
            expect_at(c_SEL_PAD_I, 0, 8'hFF, 8'h00, "rst_pad_i");
            expect_at(c_SEL_IN,    0, 8'hFF, 8'h00, "rst_in");
            expect_at(c_SEL_PEND,  0, 8'hFF, 8'h00, "rst_pend");
            expect_at(c_SEL_IRQ,   0, 8'h01, 8'h00, "rst_irq");
            randomize_inputs();
        end

        // Release with known configuration; pad drive appears one edge later.
        rst = 1'b0; dir = 8'h0F; out = 8'h05; pu_en = 8'hFF; db_thr = 8'd4;
        irq_en = 8'h00; irq_type = 16'h0000; irq_clr = 8'h00; pad_c = 8'h00;
        expect_at(c_SEL_OEN,   1, 8'hFF, 8'hF0, "drv_oen");
        expect_at(c_SEL_PAD_I, 1, 8'hFF, 8'h05, "drv_pad_i");
        expect_at(c_SEL_REN,   1, 8'hFF, 8'h00, "drv_ren");
        step(1);
        dir = 8'h00; out = 8'h00;
        step(2);

        // T=4: filtered value lands 6 edges after the pad changes.
        pad_c[0] = 1'b1;
        for (int d = 1; d <= 5; d++) expect_at(c_SEL_IN, d, 8'h01, 8'h00, "db_pin0_early");
        expect_at(c_SEL_IN, 6, 8'h01, 8'h01, "db_pin0_rise");
        step(8);

        // 3-cycle glitch is shorter than T and must be swallowed.
        pad_c[1] = 1'b1;
        for (int d = 1; d <= 10; d++) expect_at(c_SEL_IN, d, 8'h03, 8'h01, "db_glitch");
        step(3);
        pad_c[1] = 1'b0;
        step(10);

        // pin2 rise, pin3 fall, pin4 both, pin5 level.
        irq_type = 16'h0E40;
        irq_en   = 8'h3C;
        expect_at(c_SEL_PEND, 2, 8'hFF, 8'h00, "pend_idle");
        expect_at(c_SEL_IRQ,  2, 8'h01, 8'h00, "irq_idle");
        step(3);

        pad_c[4:2] = 3'b111;
        expect_at(c_SEL_PEND, 6, 8'h3C, 8'h00, "rise_early");
        expect_at(c_SEL_PEND, 7, 8'h3C, 8'h14, "rise_set");
        expect_at(c_SEL_IRQ,  6, 8'h01, 8'h00, "rise_irq_early");
        expect_at(c_SEL_IRQ,  7, 8'h01, 8'h01, "rise_irq");
        step(9);

        irq_clr = 8'h14;
        expect_at(c_SEL_PEND, 1, 8'h3C, 8'h00, "clr_rise");
        expect_at(c_SEL_IRQ,  1, 8'h01, 8'h00, "clr_irq");
        step(1);
        irq_clr = 8'h00;
        step(2);

        pad_c[4:2] = 3'b000;
        expect_at(c_SEL_PEND, 6, 8'h3C, 8'h00, "fall_early");
        expect_at(c_SEL_PEND, 7, 8'h3C, 8'h18, "fall_set");
        expect_at(c_SEL_PEND, 9, 8'h3C, 8'h18, "fall_hold");
        step(10);

        irq_clr = 8'h18;
        expect_at(c_SEL_PEND, 1, 8'hFF, 8'h00, "clr_fall");
        step(1);
        irq_clr = 8'h00;
        step(2);

        // Set pin2, clear it, then collide a new rise with a clear.
        pad_c[2] = 1'b1;
        expect_at(c_SEL_PEND, 7, 8'h3C, 8'h04, "coll_set");
        step(9);
        irq_clr = 8'h04;
        expect_at(c_SEL_PEND, 1, 8'h3C, 8'h00, "coll_clear");
        step(1);
        irq_clr = 8'h00;
        pad_c[2] = 1'b0;
        expect_at(c_SEL_PEND, 8, 8'h3C, 8'h00, "coll_fall_quiet");
        step(9);
        pad_c[2] = 1'b1;
        expect_at(c_SEL_PEND, 7, 8'h04, 8'h04, "coll_set_wins");
        expect_at(c_SEL_PEND, 8, 8'h04, 8'h04, "coll_hold");
        step(6);
        irq_clr = 8'h04;
        step(1);
        irq_clr = 8'h00;
        step(3);

        // Level type: clear is ineffective while the level is held.
        pad_c[5] = 1'b1;
        expect_at(c_SEL_PEND, 7, 8'h20, 8'h20, "lvl_set");
        step(9);
        irq_clr = 8'h20;
        expect_at(c_SEL_PEND, 1, 8'h20, 8'h20, "lvl_clr_held1");
        expect_at(c_SEL_PEND, 2, 8'h20, 8'h20, "lvl_clr_held2");
        step(1);
        irq_clr = 8'h00;
        step(2);

        irq_en = 8'h38;
        expect_at(c_SEL_PEND, 2, 8'h04, 8'h04, "en_off_keeps");
        step(3);

        pad_c[5] = 1'b0;
        expect_at(c_SEL_PEND, 8, 8'h20, 8'h20, "lvl_sticky");
        step(9);
        irq_clr = 8'h24;
        expect_at(c_SEL_PEND, 1, 8'hFF, 8'h00, "lvl_cleared");
        expect_at(c_SEL_IRQ,  1, 8'h01, 8'h00, "lvl_irq_low");
        expect_at(c_SEL_IRQ,  3, 8'h01, 8'h00, "lvl_irq_stay");
        step(1);
        irq_clr = 8'h00;
        step(3);

        // Reset in the middle of a 200-cycle debounce.
        db_thr   = 8'd200;
        pad_c[6] = 1'b1;
        step(102);
        rst = 1'b1;
        expect_at(c_SEL_IN,   1, 8'hFF, 8'h00, "mid_rst_in");
        expect_at(c_SEL_PEND, 1, 8'hFF, 8'h00, "mid_rst_pend");
        expect_at(c_SEL_OEN,  1, 8'hFF, 8'hFF, "mid_rst_oen");
        step(2);
        rst   = 1'b0;
        pad_c = 8'h40;
        expect_at(c_SEL_IN, 150, 8'h40, 8'h00, "refilter_150");
        expect_at(c_SEL_IN, 201, 8'h40, 8'h00, "refilter_201");
        expect_at(c_SEL_IN, 202, 8'h40, 8'h40, "refilter_202");
        step(205);

        for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
